// File: rtl/reduce_unit_if.sv
// Data-path bundle for reduce_unit: unreduced word and width select in,
// combinational and registered reduced results out.
// Optional: REDUCE_ERR_CNT_EN adds the saturating reserved-encoding counter.
interface reduce_unit_if;
    logic [31:0] BaseResult;
    logic [2:0]  width_src_i;
    logic [31:0] result_o;
    logic [31:0] result_q_o;
    logic        width_err_q_o;
`ifdef REDUCE_ERR_CNT_EN
    logic [7:0]  err_cnt_o;
`endif

    // Producer side: drives the word and select, observes results.
    modport master (
        output BaseResult,
        output width_src_i,
        input  result_o,
        input  result_q_o,
`ifdef REDUCE_ERR_CNT_EN
        input  err_cnt_o,
`endif
        input  width_err_q_o
    );

    // Reducer side.
    modport slave (
        input  BaseResult,
        input  width_src_i,
        output result_o,
        output result_q_o,
`ifdef REDUCE_ERR_CNT_EN
        output err_cnt_o,
`endif
        output width_err_q_o
    );
endinterface

// File: rtl/reduce_unit.sv
// Load-data width reducer: passes a 32-bit word through or reduces it to the
// low halfword/byte with sign or zero extension. width_src_i[2] = unsigned,
// width_src_i[1:0] = size (00 word, 10 half, 01 byte, 11 reserved -> 0).
// Optional: REDUCE_ERR_CNT_EN adds err_cnt_o, a saturating count of cycles
// that saw a reserved encoding.
module reduce_unit (
    input logic         clk_i,
    input logic         rst_n_i,
    reduce_unit_if.slave bus
);

    logic [31:0] result;
    logic        sign_ext;
    logic        width_err;

    assign sign_ext  = ~bus.width_src_i[2];
    assign width_err = (bus.width_src_i[1:0] == 2'b11);

    // Combinational reduction; reserved sizes yield zero.
    always_comb begin
        result = 32'h0000_0000;
        unique case (bus.width_src_i[1:0])
            2'b00: result = bus.BaseResult;
            2'b10: result = {{16{sign_ext & bus.BaseResult[15]}}, bus.BaseResult[15:0]};
            2'b01: result = {{24{sign_ext & bus.BaseResult[7]}}, bus.BaseResult[7:0]};
            2'b11: result = 32'h0000_0000;
            default: result = 32'h0000_0000;
        endcase
    end

    assign bus.result_o = result;

    logic [31:0] result_q;
    logic        width_err_q;

    // Registered copy of the result and the reserved-encoding flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            result_q    <= 32'h0000_0000;
            width_err_q <= 1'b0;
        end else begin
            result_q    <= result;
            width_err_q <= width_err;
        end
    end

    assign bus.result_q_o    = result_q;
    assign bus.width_err_q_o = width_err_q;

`ifdef REDUCE_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of reserved-encoding cycles.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_q <= 8'h00;
        end else if (width_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_reduce_unit.sv
// Directed self-checking bench for reduce_unit.
module tb_reduce_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reduce_unit_if bus ();

    reduce_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    localparam int NumVec = 18;
    logic [31:0] vec_base [NumVec] = '{
        32'hDEAD_BEEF, 32'hDEAD_BEEF,
        32'h1234_8001, 32'h1234_8001,
        32'hFFFF_7FFF, 32'hFFFF_7FFF,
        32'h0000_0080, 32'h0000_0080,
        32'hFFFF_FF7F, 32'hFFFF_FF7F,
        32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hA5A5_C3F0, 32'hA5A5_C3F0, 32'hA5A5_C3F0, 32'hA5A5_C3F0,
        32'h5A5A_5A5A, 32'h5A5A_5A5A
    };
    logic [2:0] vec_sel [NumVec] = '{
        3'b000, 3'b100,
        3'b010, 3'b110,
        3'b010, 3'b110,
        3'b001, 3'b101,
        3'b001, 3'b101,
        3'b011, 3'b111,
        3'b001, 3'b101, 3'b010, 3'b110,
        3'b011, 3'b000
    };
    logic [31:0] vec_exp [NumVec] = '{
        32'hDEAD_BEEF, 32'hDEAD_BEEF,
        32'hFFFF_8001, 32'h0000_8001,
        32'h0000_7FFF, 32'h0000_7FFF,
        32'hFFFF_FF80, 32'h0000_0080,
        32'h0000_007F, 32'h0000_007F,
        32'h0000_0000, 32'h0000_0000,
        32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_C3F0, 32'h0000_C3F0,
        32'h0000_0000, 32'h5A5A_5A5A
    };

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.BaseResult  = 32'h0000_F00D;
        bus.width_src_i = 3'b010;

        // Reset state, and combinational path alive during reset.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_result_q", bus.result_q_o, 32'h0);
        check_val("rst_width_err_q", {31'b0, bus.width_err_q_o}, 32'h0);
        check_val("rst_result_comb", bus.result_o, 32'hFFFF_F00D);

        // First capture only on the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("release_pre_edge", bus.result_q_o, 32'h0);
        @(posedge clk);
        #1;
        check_val("release_capture", bus.result_q_o, 32'hFFFF_F00D);

        // Combinational vectors, checked 1 ns after apply.
        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            bus.BaseResult  = vec_base[i];
            bus.width_src_i = vec_sel[i];
            #1;
            check_val($sformatf("comb_%0d_sel%b", i, vec_sel[i]), bus.result_o, vec_exp[i]);
        end

        // Reserved encodings raise the registered flag after the edge.
        @(negedge clk);
        bus.BaseResult  = 32'hFFFF_FFFF;
        bus.width_src_i = 3'b011;
        @(posedge clk);
        #1;
        check_val("err_q_011", {31'b0, bus.width_err_q_o}, 32'h1);
        check_val("result_q_011", bus.result_q_o, 32'h0);
        @(negedge clk);
        bus.width_src_i = 3'b111;
        @(posedge clk);
        #1;
        check_val("err_q_111", {31'b0, bus.width_err_q_o}, 32'h1);

        // Registered path, then async reset between edges.
        @(negedge clk);
        bus.BaseResult  = 32'h0000_F00D;
        bus.width_src_i = 3'b010;
        @(posedge clk);
        #1;
        check_val("reg_result_q", bus.result_q_o, 32'hFFFF_F00D);
        check_val("reg_err_clear", {31'b0, bus.width_err_q_o}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_result_q", bus.result_q_o, 32'h0);
        check_val("async_rst_comb", bus.result_o, 32'hFFFF_F00D);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset also clears a set error flag.
        bus.BaseResult  = 32'hFFFF_FFFF;
        bus.width_src_i = 3'b111;
        @(posedge clk);
        #1;
        check_val("err_set_again", {31'b0, bus.width_err_q_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_err_q", {31'b0, bus.width_err_q_o}, 32'h0);
        check_val("async_rst_comb_rsv", bus.result_o, 32'h0);

`ifdef REDUCE_ERR_CNT_EN
        check_val("cnt_rst", {24'b0, bus.err_cnt_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.width_src_i = 3'b011;
        repeat (5) @(posedge clk);
        #1;
        check_val("cnt_5", {24'b0, bus.err_cnt_o}, 32'd5);
        @(negedge clk);
        bus.width_src_i = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_val("cnt_hold", {24'b0, bus.err_cnt_o}, 32'd5);
        @(negedge clk);
        bus.width_src_i = 3'b111;
        repeat (295) @(posedge clk);
        #1;
        check_val("cnt_300_sat", {24'b0, bus.err_cnt_o}, 32'hFF);
        repeat (4) @(posedge clk);
        #1;
        check_val("cnt_no_wrap", {24'b0, bus.err_cnt_o}, 32'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
